// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
//   req_valid/req_write/req_addr/req_wdata : request from the pipeline (master)
//   req_ready                              : responder can take a request this cycle
//   resp_valid/resp_rdata/resp_err         : one-cycle response
//   stall                                  : freeze request to the hazard unit
interface dmem_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage of the pipelined core.
// Accepts one word load/store at a time, answers LATENCY cycles after acceptance
// and holds the pipeline frozen while the request is outstanding.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset (clears FSM, latched request and array)
//   bus   : dmem_if slave side (request handshake, response, stall)
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 3
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] mem_d [DEPTH_WORDS];

  logic            addr_err;
  logic [IdxW-1:0] idx;

  // Decoded from the latched address only, so the response has no path from req_*.
  assign idx      = addr_q[IdxW+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mem_d   = mem_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY > 1) ? StWait : StResp;
        end
      end
      StWait: begin
        // Counter stops at the transition to RESP, so it never wraps.
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        // Store commits on the edge leaving RESP; a reset before then drops it.
        if (wr_q && !addr_err) begin
          mem_d[idx] = wdata_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_err   = (state_q == StResp) && addr_err;
  assign bus.resp_rdata = ((state_q == StResp) && !wr_q && !addr_err) ? mem_q[idx] : 32'h0;
  // Freeze in the acceptance cycle too; release in RESP so the pipeline advances.
  assign bus.stall      = (state_q == StWait) || ((state_q == StIdle) && bus.req_valid);

endmodule
